cordic_rr_sched: RTL

Round-robin scheduler that time-shares one pipelined `cordic16` rotator among `NREQ` requesters (NCO, mixer and demodulator channels). It accepts at most one rotation per clock through per-requester valid/ready handshakes and drives the CORDIC input with `i_ce` held high. A tag pipeline matched to the CORDIC latency returns each result to the requester that issued it. The block sits between the channel datapaths and the single shared `cordic16` instance.

---
 rtl/cordic_pkg.sv | 16 +
 rtl/cordic_rr_arbiter.sv | 56 +++++
 rtl/cordic_rr_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and tag type for the cordic16 front-end.
// Latency/width values match the cordic16 core; tag ids sized for up to 8 requesters.
package cordic_pkg;

    localparam int CORDIC_LAT = 21;
    localparam int CORDIC_PW  = 23;
    localparam int CORDIC_IW  = 16;
    localparam int CORDIC_OW  = 16;
    localparam int CORDIC_IDW = 3;

    typedef struct packed {
        logic                  vld;
        logic [CORDIC_IDW-1:0] id;
    } cordic_tag_t;

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Round-robin arbiter with optional strict priority for requester 0.
// Ports: i_clk, i_reset, i_req, i_prio0_en -> o_gnt (one-hot), o_gnt_id, o_gnt_vld.
module cordic_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NREQ-1:0]         i_req,
    input  logic                    i_prio0_en,
    output logic [NREQ-1:0]         o_gnt,
    output logic [$clog2(NREQ)-1:0] o_gnt_id,
    output logic                    o_gnt_vld
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr;
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    logic           prio_hit;

    // Scan offsets from far to near so the nearest valid after ptr wins.
    always_comb begin
        o_gnt_id  = '0;
        o_gnt_vld = 1'b0;
        sum       = '0;
        cand      = '0;
        prio_hit  = i_prio0_en & i_req[0];
        if (!i_reset) begin
            if (prio_hit) begin
                o_gnt_vld = 1'b1;
            end else begin
                for (int k = NREQ; k >= 1; k--) begin
                    sum = {1'b0, ptr} + (IDW+1)'(k);
                    if (sum >= (IDW+1)'(NREQ))
                        sum = sum - (IDW+1)'(NREQ);
                    cand = sum[IDW-1:0];
                    if (i_req[cand]) begin
                        o_gnt_id  = cand;
                        o_gnt_vld = 1'b1;
                    end
                end
            end
        end
        o_gnt = o_gnt_vld ? (NREQ'(1) << o_gnt_id) : '0;
    end

    // Priority grants to requester 0 leave the rotation untouched.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            ptr <= IDW'(NREQ - 1);
        else if (o_gnt_vld && !prio_hit)
            ptr <= o_gnt_id;
    end

endmodule

// File: rtl/cordic_rr_sched.sv
// Time-shares one pipelined cordic16 among NREQ requesters and routes results back.
// Ports: per-requester req valid/ready/x/y/phase, CORDIC ce/x/y/phase/aux out,
// CORDIC x/y/aux in, one-hot result strobe with shared id/x/y bus, sticky o_err.
// Build macro CORDIC_SCHED_PRIO0_EN: requester 0 gets strict priority.
module cordic_rr_sched
    import cordic_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = CORDIC_IW,
    parameter int OW   = CORDIC_OW,
    parameter int PW   = CORDIC_PW,
    parameter int LAT  = CORDIC_LAT
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NREQ-1:0]         i_req_valid,
    output logic [NREQ-1:0]         o_req_ready,
    input  logic [NREQ*IW-1:0]      i_req_x,
    input  logic [NREQ*IW-1:0]      i_req_y,
    input  logic [NREQ*PW-1:0]      i_req_phase,
    output logic                    o_cordic_ce,
    output logic [IW-1:0]           o_cordic_x,
    output logic [IW-1:0]           o_cordic_y,
    output logic [PW-1:0]           o_cordic_phase,
    output logic                    o_cordic_aux,
    input  logic [OW-1:0]           i_cordic_x,
    input  logic [OW-1:0]           i_cordic_y,
    input  logic                    i_cordic_aux,
    output logic [NREQ-1:0]         o_res_valid,
    output logic [$clog2(NREQ)-1:0] o_res_id,
    output logic [OW-1:0]           o_res_x,
    output logic [OW-1:0]           o_res_y,
    output logic                    o_err
);

    localparam int IDW = $clog2(NREQ);

    logic           prio0_en;
    logic [IDW-1:0] gnt_id;
    logic           gnt_vld;
    logic [IDW-1:0] iss_id;
    cordic_tag_t    tag_q [LAT];
    cordic_tag_t    tail;

`ifdef CORDIC_SCHED_PRIO0_EN
    assign prio0_en = 1'b1;
`else
    assign prio0_en = 1'b0;
`endif

    cordic_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_req      (i_req_valid),
        .i_prio0_en (prio0_en),
        .o_gnt      (o_req_ready),
        .o_gnt_id   (gnt_id),
        .o_gnt_vld  (gnt_vld)
    );

    // Issue register: ready equals grant, so a grant is always a transfer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_cordic_ce    <= 1'b0;
            o_cordic_aux   <= 1'b0;
            o_cordic_x     <= '0;
            o_cordic_y     <= '0;
            o_cordic_phase <= '0;
            iss_id         <= '0;
        end else begin
            o_cordic_ce  <= 1'b1;
            o_cordic_aux <= gnt_vld;
            if (gnt_vld) begin
                o_cordic_x     <= i_req_x[gnt_id*IW +: IW];
                o_cordic_y     <= i_req_y[gnt_id*IW +: IW];
                o_cordic_phase <= i_req_phase[gnt_id*PW +: PW];
                iss_id         <= gnt_id;
            end
        end
    end

    // Tag pipeline tracks the CORDIC aux line; its tail lines up with i_cordic_aux.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < LAT; i++)
                tag_q[i] <= '0;
        end else begin
            tag_q[0].vld <= o_cordic_aux;
            tag_q[0].id  <= CORDIC_IDW'(iss_id);
            for (int i = 1; i < LAT; i++)
                tag_q[i] <= tag_q[i-1];
        end
    end

    assign tail = tag_q[LAT-1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_res_valid <= '0;
            o_res_id    <= '0;
            o_res_x     <= '0;
            o_res_y     <= '0;
            o_err       <= 1'b0;
        end else begin
            o_res_valid <= tail.vld ? (NREQ'(1) << tail.id) : '0;
            o_res_id    <= tail.id[IDW-1:0];
            o_res_x     <= i_cordic_x;
            o_res_y     <= i_cordic_y;
            if (tail.vld != i_cordic_aux)
                o_err <= 1'b1;
        end
    end

endmodule
